// File: rtl/regfile_wr_sched_if.sv
// Write-port scheduler bus bundle: core writeback, decode sources for the
// hazard check, LSU load-return handshake, and the register-file write port.
//   master : core/LSU side (drives requests, observes port and status)
//   slave  : scheduler side (observes requests, drives port and status)
interface regfile_wr_sched_if;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    // core writeback and decode sources
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;

    // LSU load-return handshake
    logic          lsu_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wd;
    logic          lsu_ready;

    // register-file write port
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;

    // status toward the core
    logic          init_busy;
    logic          core_stall;
    logic          rd_hazard;

    modport master (
        output core_we, core_addr, core_wd, rs1, rs2,
        output lsu_valid, lsu_addr, lsu_wd,
        input  lsu_ready,
        input  WE3, A3, WD3,
        input  init_busy, core_stall, rd_hazard
    );

    modport slave (
        input  core_we, core_addr, core_wd, rs1, rs2,
        input  lsu_valid, lsu_addr, lsu_wd,
        output lsu_ready,
        output WE3, A3, WD3,
        output init_busy, core_stall, rd_hazard
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file.
// After reset it zero-fills every register (the file has no clear of its own),
// then merges single-cycle core writebacks with late LSU load returns held in
// a 2-entry FIFO, with WAW kill, read-hazard flagging and starvation stalls.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : regfile_wr_sched_if.slave (core/LSU requests in; WE3/A3/WD3,
//          lsu_ready, init_busy, core_stall, rd_hazard out)
// WE3/A3/WD3, lsu_ready and rd_hazard are combinational so the file captures
// the write at the same edge the queue pops.
module regfile_wr_sched #(
    parameter int unsigned NREG       = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic               clk,
    input logic               rst,
    regfile_wr_sched_if.slave bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned QD    = 2;
    localparam int unsigned CNT_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned SW    = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic          occ;
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } qent_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    qent_t [QD-1:0]    q_q, q_d;

    logic              run_c;
    logic              head_live_c;
    logic              starve_drain_c;
    logic              core_acc_c;
    logic              head_drain_c;
    logic              pop_c;
    logic              lsu_ready_c;
    logic              push_c;
    logic              we_c;
    logic [AW-1:0]     a3_c;
    logic [DW-1:0]     wd3_c;
    logic              hazard_c;

    // State register: phase, INIT counter, starvation counter, FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            starve_q <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            q_q      <= q_d;
        end
    end

    // Next-state, queue update and write-port arbitration.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        q_d      = q_q;
        we_c     = 1'b0;
        a3_c     = '0;
        wd3_c    = '0;
        hazard_c = 1'b0;

        run_c          = (state_q == ST_RUN);
        head_live_c    = q_q[0].occ & q_q[0].live;
        starve_drain_c = run_c & head_live_c & (starve_q == SW'(STARVE_LIM));
        core_acc_c     = run_c & ~starve_drain_c & bus.core_we & (bus.core_addr != '0);
        // a dead head also pops here, just without a write
        head_drain_c   = run_c & ~starve_drain_c & ~core_acc_c & q_q[0].occ;
        pop_c          = starve_drain_c | head_drain_c;
        // entries stay compacted toward slot 0, so slot 1 occupied means full
        lsu_ready_c    = run_c & ~q_q[1].occ;
        push_c         = bus.lsu_valid & lsu_ready_c & (bus.lsu_addr != '0);

        case (state_q)
            ST_INIT: begin
                we_c = 1'b1;
                a3_c = AW'(cnt_q);
                if (cnt_q == CNT_W'(NREG - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (starve_drain_c) begin
                    we_c  = 1'b1;
                    a3_c  = q_q[0].addr;
                    wd3_c = q_q[0].data;
                end else if (core_acc_c) begin
                    we_c  = 1'b1;
                    a3_c  = bus.core_addr;
                    wd3_c = bus.core_wd;
                end else if (head_drain_c && q_q[0].live) begin
                    we_c  = 1'b1;
                    a3_c  = q_q[0].addr;
                    wd3_c = q_q[0].data;
                end

                // read hazard against any live queued destination
                for (int unsigned i = 0; i < QD; i++) begin
                    if (q_q[i].occ && q_q[i].live && (q_q[i].addr != '0) &&
                        ((q_q[i].addr == bus.rs1) || (q_q[i].addr == bus.rs2))) begin
                        hazard_c = 1'b1;
                    end
                end

                // younger core write kills older queued writes to the same reg
                for (int unsigned i = 0; i < QD; i++) begin
                    if (core_acc_c && q_q[i].occ && (q_q[i].addr == bus.core_addr)) begin
                        q_d[i].live = 1'b0;
                    end
                end

                if (pop_c) begin
                    q_d[0] = q_d[1];
                    q_d[1] = '0;
                end

                // append after the pop; x0 pushes complete but are dropped
                if (push_c) begin
                    if (!q_d[0].occ) begin
                        q_d[0] = '{occ: 1'b1, live: 1'b1, addr: bus.lsu_addr, data: bus.lsu_wd};
                    end else begin
                        q_d[1] = '{occ: 1'b1, live: 1'b1, addr: bus.lsu_addr, data: bus.lsu_wd};
                    end
                end

                if (pop_c || !head_live_c) begin
                    starve_d = '0;
                end else if (starve_q != SW'(STARVE_LIM)) begin
                    starve_d = starve_q + SW'(1);
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // hold the write port quiet while reset is asserted
        if (!rst) begin
            we_c     = 1'b0;
            a3_c     = '0;
            wd3_c    = '0;
            hazard_c = 1'b0;
        end
    end

    assign bus.WE3        = we_c;
    assign bus.A3         = a3_c;
    assign bus.WD3        = wd3_c;
    assign bus.lsu_ready  = lsu_ready_c;
    assign bus.rd_hazard  = hazard_c;
    assign bus.init_busy  = (state_q == ST_INIT);
    assign bus.core_stall = (state_q == ST_INIT) | starve_drain_c;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_regfile_wr_sched;
    localparam int unsigned NREG = 32;
    localparam int unsigned LIM  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wr_sched_if bus ();

    regfile_wr_sched #(.NREG(NREG), .STARVE_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
    } ent_t;

    // reference model state
    ent_t      mq[$];
    bit        m_init;
    int        m_cnt;
    int        m_starve;
    bit [31:0] m_file [32];
    bit [31:0] dut_file [32];

    // last observed outputs
    logic        o_we, o_ready, o_busy, o_stall, o_haz;
    logic [4:0]  o_a3;
    logic [31:0] o_wd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit we, input bit [4:0] ca, input bit [31:0] cd,
                         input bit lv, input bit [4:0] la, input bit [31:0] ld,
                         input bit [4:0] r1, input bit [4:0] r2);
        bus.core_we   = we;
        bus.core_addr = ca;
        bus.core_wd   = cd;
        bus.lsu_valid = lv;
        bus.lsu_addr  = la;
        bus.lsu_wd    = ld;
        bus.rs1       = r1;
        bus.rs2       = r2;
    endtask

    // One clock cycle: predict, check mid-cycle, advance model at the edge.
    task automatic step();
        bit        e_we, e_ready, e_busy, e_stall, e_haz;
        bit        starve, core_ok, pop, hlive;
        bit [4:0]  e_a;
        bit [31:0] e_d;

        if (!rst) begin
            mq.delete();
            m_init   = 1'b1;
            m_cnt    = 0;
            m_starve = 0;
        end

        e_we = 0; e_a = 0; e_d = 0; e_ready = 0; e_busy = 1; e_stall = 1; e_haz = 0;
        starve = 0; core_ok = 0; pop = 0; hlive = 0;

        if (rst && m_init) begin
            e_we = 1;
            e_a  = 5'(m_cnt);
        end else if (rst) begin
            e_busy  = 0;
            e_ready = (mq.size() < 2);
            foreach (mq[i]) begin
                if (mq[i].live && ((bus.rs1 != 0 && mq[i].addr == bus.rs1) ||
                                   (bus.rs2 != 0 && mq[i].addr == bus.rs2)))
                    e_haz = 1;
            end
            hlive   = (mq.size() > 0) && mq[0].live;
            starve  = hlive && (m_starve == LIM);
            core_ok = !starve && bus.core_we && (bus.core_addr != 0);
            e_stall = starve;
            if (starve) begin
                e_we = 1; e_a = mq[0].addr; e_d = mq[0].data; pop = 1;
            end else if (core_ok) begin
                e_we = 1; e_a = bus.core_addr; e_d = bus.core_wd;
            end else if (mq.size() > 0) begin
                pop = 1;
                if (mq[0].live) begin
                    e_we = 1; e_a = mq[0].addr; e_d = mq[0].data;
                end
            end
        end

        #1;
        o_we = bus.WE3; o_a3 = bus.A3; o_wd = bus.WD3;
        o_ready = bus.lsu_ready; o_busy = bus.init_busy;
        o_stall = bus.core_stall; o_haz = bus.rd_hazard;
        check_eq("we3", 32'(o_we), 32'(e_we));
        check_eq("a3", 32'(o_a3), 32'(e_a));
        check_eq("wd3", o_wd, e_d);
        check_eq("lsu_ready", 32'(o_ready), 32'(e_ready));
        check_eq("init_busy", 32'(o_busy), 32'(e_busy));
        check_eq("core_stall", 32'(o_stall), 32'(e_stall));
        check_eq("rd_hazard", 32'(o_haz), 32'(e_haz));

        @(posedge clk);
        if (o_we === 1'b1) dut_file[o_a3] = o_wd;
        if (rst && m_init) begin
            m_file[m_cnt] = 0;
            if (m_cnt == NREG - 1) begin
                m_init = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end else if (rst) begin
            if (e_we) m_file[e_a] = e_d;
            if (core_ok) begin
                foreach (mq[i]) if (mq[i].addr == bus.core_addr) mq[i].live = 0;
            end
            if (pop || !hlive) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
            if (pop) void'(mq.pop_front());
            if (bus.lsu_valid && e_ready && bus.lsu_addr != 0)
                mq.push_back('{1'b1, bus.lsu_addr, bus.lsu_wd});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        m_init = 1; m_cnt = 0; m_starve = 0;
        for (int r = 0; r < 32; r++) begin
            m_file[r]   = 32'hA5A5_A5A5;
            dut_file[r] = 32'hA5A5_A5A5;
        end

        // reset held, then release into INIT
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        repeat (NREG) step();
        step();
        check_eq("init_done_busy", 32'(o_busy), 32'd0);
        check_eq("run_ready", 32'(o_ready), 32'd1);

        // single LSU write with no core traffic, hazard while queued
        drive(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        step();
        check_eq("lsu_we", 32'(o_we), 32'd1);
        check_eq("lsu_a3", 32'(o_a3), 32'd5);
        check_eq("lsu_wd3", o_wd, 32'hDEAD_BEEF);
        check_eq("lsu_hazard", 32'(o_haz), 32'd1);
        idle();
        step();

        // queue fills under continuous core writes, then starvation drains
        drive(1, 10, $urandom, 1, 6, 32'h66, 0, 0);
        step();
        drive(1, 10, $urandom, 1, 7, 32'h77, 0, 0);
        step();
        drive(1, 10, $urandom, 1, 9, 32'h99, 0, 0);
        step();
        check_eq("full_ready", 32'(o_ready), 32'd0);
        drive(1, 10, $urandom, 0, 0, 0, 0, 0);
        repeat (2) step();
        step();
        check_eq("starve6_stall", 32'(o_stall), 32'd1);
        check_eq("starve6_a3", 32'(o_a3), 32'd6);
        repeat (4) step();
        step();
        check_eq("starve7_stall", 32'(o_stall), 32'd1);
        check_eq("starve7_a3", 32'(o_a3), 32'd7);
        idle();
        step();

        // WAW kill: queued x8 killed by younger core write
        drive(1, 10, $urandom, 1, 8, 32'h1, 0, 0);
        step();
        drive(1, 8, 32'h2, 0, 0, 0, 0, 0);
        step();
        idle();
        step();
        check_eq("waw_dead_pop_we", 32'(o_we), 32'd0);
        step();
        check_eq("waw_file_x8", dut_file[8], 32'h2);

        // x0 handling on both sides
        drive(0, 0, 0, 1, 0, 32'h55, 0, 0);
        step();
        check_eq("x0_push_ready", 32'(o_ready), 32'd1);
        idle();
        step();
        check_eq("x0_not_stored", 32'(o_we), 32'd0);
        drive(1, 10, $urandom, 1, 12, 32'hC0C0, 0, 0);
        step();
        drive(1, 0, 32'hBAD, 0, 0, 0, 0, 0);
        step();
        check_eq("x0_core_drain_we", 32'(o_we), 32'd1);
        check_eq("x0_core_drain_a3", 32'(o_a3), 32'd12);
        check_eq("x0_core_drain_wd", o_wd, 32'hC0C0);

        // reset mid-RUN with a full queue
        drive(1, 10, $urandom, 1, 6, 32'h600, 0, 0);
        step();
        drive(1, 10, $urandom, 1, 7, 32'h700, 0, 0);
        step();
        drive(1, 10, $urandom, 0, 0, 0, 6, 7);
        rst = 1'b0;
        step();
        check_eq("rst_mid_hazard", 32'(o_haz), 32'd0);
        check_eq("rst_mid_we", 32'(o_we), 32'd0);
        step();
        rst = 1'b1;
        idle();
        repeat (NREG) step();
        step();
        check_eq("reinit_done_busy", 32'(o_busy), 32'd0);

        // random traffic with small address range to force collisions
        repeat (600) begin
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        idle();
        repeat (LIM + 4) step();

        for (int r = 0; r < 32; r++)
            check_eq($sformatf("file_x%0d", r), dut_file[r], m_file[r]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler for the 32×32 register file. It owns the file's single write port (`A3`/`WD3`/`WE3`) and runs two phases:
- **INIT:** after reset it zero-fills every register, because the file itself has no reset clear.
- **RUN:** it merges single-cycle core writebacks with late load-return writes from the LSU. LSU writes are buffered in a 2-entry queue, with read-hazard and starvation control toward the core.

It sits between the core's writeback stage/LSU and the register file.

## Interface
Parameters:
- `NREG`, 32: registers to clear in INIT; the counter wraps at `NREG`.
- `STARVE_LIM`, 4: cycles a queued LSU write may wait before forcing a core stall.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `core_we`, in, 1: core writeback request this cycle.
- `core_addr`, in, 5: core destination register.
- `core_wd`, in, 32: core write data.
- `rs1`, in, 5: core source register 1 (decode), for hazard check.
- `rs2`, in, 5: core source register 2 (decode), for hazard check.
- `lsu_valid`, in, 1: LSU load-return write offered.
- `lsu_addr`, in, 5: LSU destination register.
- `lsu_wd`, in, 32: LSU write data.
- `lsu_ready`, out, 1: queue can accept; transfer occurs when `lsu_valid & lsu_ready` at the edge.
- `WE3`, out, 1: register-file write enable.
- `A3`, out, 5: register-file write address.
- `WD3`, out, 32: register-file write data.
- `init_busy`, out, 1: INIT phase active.
- `core_stall`, out, 1: core must hold its current instruction; `core_we` is ignored this cycle.
- `rd_hazard`, out, 1: `rs1` or `rs2` (nonzero) matches a live queued entry.

## Operation
**State machine (INIT, RUN):**
- Reset → INIT with `cnt = 0`.
- INIT: `WE3 = 1`, `A3 = cnt`, `WD3 = 0`; `cnt` increments each edge.
- INIT → RUN on the edge where `cnt == NREG-1`.
- RUN has no exit except reset.

**INIT outputs:**
- `init_busy = 1`, `core_stall = 1`, `lsu_ready = 0`, `rd_hazard = 0`.
- Core and LSU inputs are ignored.

**Queue:** 2 entries, each `{live, addr, data}`, in FIFO order.
- `lsu_ready = 1` in RUN when fewer than 2 entries are occupied; an occupied-but-dead entry still counts as occupied.
- A push with `lsu_addr == 0` is accepted (handshake completes) but not stored.
- A push becomes visible for draining starting the next cycle; there is no same-cycle bypass.

**RUN write-port priority:**
1. **Starve drain:** head live and `starve_cnt == STARVE_LIM`. Write the head; `core_stall = 1`; pop.
2. **Core write:** `core_we = 1` and `core_addr != 0`. Drive the port from the core.
3. **Head drain:** the head is written when live; a dead head is popped with `WE3 = 0`.
4. **Idle:** otherwise `WE3 = 0`, and `A3`/`WD3` are 0.
- Core writes to x0 never assert `WE3`, and they leave the port free for rule 3.

**Starvation counter:**
- Increments each edge while the head is live and not popped.
- Clears on pop or when the queue is empty; saturates at `STARVE_LIM`.

**WAW kill:**
- A core write accepted in RUN (not stalled, addr nonzero) clears `live` on every queued entry with the same addr at that edge, because the core write is program-order younger.
- A push arriving in that same cycle is not killed.

**Hazard:**
- `rd_hazard` is combinational: any live entry with `addr == rs1` or `addr == rs2`, where the matched address is nonzero.
- The core stalls itself on `rd_hazard`; the block does not gate `core_we` on it.

**Stall:** `core_stall = init_busy | starve_drain`.

**Reset mid-operation:**
- Queue empties, `cnt = 0`, `starve_cnt = 0`, state → INIT.
- While `rst` is low: `WE3 = 0`, `lsu_ready = 0`, `init_busy = 1`, `core_stall = 1`, `rd_hazard = 0`, `A3 = 0`, `WD3 = 0`.
- In-flight LSU data is lost.

## Timing
- **INIT length:** exactly `NREG` cycles after the first rising edge with `rst` high. Registers 0..31 are written on edges 1..32. `init_busy` falls after edge 32.
- **LSU latency:** earliest write is the cycle after the accepting edge, landing at the following edge.
- **Worst-case LSU latency:** with a continuous core stream, `STARVE_LIM+1` cycles from head arrival to write.
- **Write-port outputs:** `WE3`/`A3`/`WD3` are combinational from state and inputs. The file captures them at the same rising edge as the queue pop.
- **Full + drain in one cycle:** `lsu_ready` stays 0 that cycle (computed from occupancy before the pop).

## Test plan
- **Reset then idle:** release `rst` → `WE3 = 1` for 32 consecutive cycles, `A3 = 0..31`, `WD3 = 0`; `init_busy` = 0 on the 33rd cycle; `lsu_ready` = 1.
- **LSU write with no core traffic:** push `x5 = 0xDEADBEEF` → next cycle `WE3 = 1`, `A3 = 5`, `WD3 = 0xDEADBEEF`. While queued with `rs1 = 5`, `rd_hazard = 1`.
- **Queue full under continuous core writes:** push x6 and x7 while `core_we = 1` (`core_addr = 10`) every cycle → `lsu_ready = 0` once full. After 4 waiting cycles, `core_stall = 1` for one cycle with `A3 = 6`. The x7 entry forces its own stall after a further 4 cycles.
- **WAW kill:** queue x8 (data `0x1`), then core write `x8 = 0x2` → no LSU write to x8 ever occurs; the dead head pops with `WE3 = 0`; the file holds `0x2`.
- **x0 writes:** LSU push to x0 completes the handshake, but the queue stays empty. Core write to x0 gives `WE3 = 0`, and a live queued entry drains in that cycle.
- **Reset mid-RUN:** pull `rst` low with 2 entries queued → outputs go to their reset values immediately (asynchronously). After release, a full 32-cycle INIT repeats with no queued writes.
